// File: rtl/chest_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chest_pkg                                                    |
// | Description : Shared constants, FSM encoding and pilot-ordering tables for |
// |               the NB-IoT frequency-domain channel-estimate interpolator.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package chest_pkg;

  localparam int NUM_SC        = 12;   // subcarriers per PRB
  localparam int NUM_PILOTS    = 4;    // pilots across both NRS symbols
  localparam int PILOT_SPACING = 3;    // combined pilot grid pitch
  localparam int RECIP3        = 683;  // round(2^11 / 3)
  localparam int RECIP3_SHIFT  = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Upstream addresses in ascending subcarrier order; slot i lives in
  // bits [2i+1:2i]. LO covers k0 < 3 (0,2,1,3), HI covers k0 >= 3 (2,0,3,1).
  localparam logic [7:0] ADDR_ORDER_LO = {2'd3, 2'd1, 2'd2, 2'd0};
  localparam logic [7:0] ADDR_ORDER_HI = {2'd1, 2'd3, 2'd0, 2'd2};

  function automatic logic [1:0] sorted_addr(input logic hi, input logic [1:0] slot);
    logic [7:0] tbl;
    tbl = hi ? ADDR_ORDER_HI : ADDR_ORDER_LO;
    return tbl[{slot, 1'b0} +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/chest_interp_div3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chest_interp_div3                                            |
// | Description : One rail of the 1/3 - 2/3 frequency interpolator.           |
// |               quot = sat((w_a*a + w_b*b) * RECIP3 >>> RECIP3_SHIFT), with  |
// |               weights (2,1) or (1,2). Floor rounding via arithmetic shift. |
// | Ports       : i_tap_a, i_tap_b - lower / upper pilot (signed WIDTH)        |
// |               i_near_b         - 1: weight 2 on i_tap_b, 0: on i_tap_a     |
// |               o_quot           - interpolated value (signed WIDTH)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chest_interp_div3 #(
  parameter int WIDTH        = 17,
  parameter int RECIP3       = 683,
  parameter int RECIP3_SHIFT = 11
) (
  input  logic signed [WIDTH-1:0] i_tap_a,
  input  logic signed [WIDTH-1:0] i_tap_b,
  input  logic                    i_near_b,
  output logic signed [WIDTH-1:0] o_quot
);

  localparam int SUM_W  = WIDTH + 2;              // 3 * full-scale fits
  localparam int PROD_W = SUM_W + RECIP3_SHIFT;

  localparam logic signed [PROD_W-1:0] c_q_max =
    {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] c_q_min =
    {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [SUM_W-1:0]  w_a;
  logic signed [SUM_W-1:0]  w_b;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [PROD_W-1:0] w_sum_x;
  logic signed [PROD_W-1:0] w_recip;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_quo;

  assign w_a     = {{2{i_tap_a[WIDTH-1]}}, i_tap_a};
  assign w_b     = {{2{i_tap_b[WIDTH-1]}}, i_tap_b};
  assign w_sum   = i_near_b ? (w_a + (w_b <<< 1)) : ((w_a <<< 1) + w_b);
  assign w_sum_x = {{RECIP3_SHIFT{w_sum[SUM_W-1]}}, w_sum};
  assign w_recip = PROD_W'(RECIP3);
  assign w_prod  = w_sum_x * w_recip;
  assign w_quo   = w_prod >>> RECIP3_SHIFT;

  // RECIP3 is slightly above 1/3, so near full scale the quotient can step
  // just past the WIDTH range; clamp instead of letting it wrap.
  always_comb begin
    if (w_quo > c_q_max) begin
      o_quot = c_q_max[WIDTH-1:0];
    end else if (w_quo < c_q_min) begin
      o_quot = c_q_min[WIDTH-1:0];
    end else begin
      o_quot = w_quo[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/chest_freq_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chest_freq_interp                                            |
// | Description : Reads the 4 NRS pilot estimates in subcarrier order and      |
// |               streams 12 linearly interpolated channel estimates.         |
// | Ports       : clk, rst      - clock, async active-high reset              |
// |               start         - frame request (ignored unless idle)         |
// |               nrs_shift     - NRS frequency shift, reduced mod 6           |
// |               rd_addr       - pilot memory read address (registered)      |
// |               est_r, est_i  - pilot read data, combinational of rd_addr   |
// |               h_r,h_i,h_sc  - interpolated estimate and its subcarrier    |
// |               h_valid       - output sample strobe                        |
// |               busy, done    - frame in progress / last-sample pulse       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chest_freq_interp import chest_pkg::*; #(
  parameter int WIDTH        = 17,
  parameter int NUM_SC       = chest_pkg::NUM_SC,
  parameter int RECIP3       = chest_pkg::RECIP3,
  parameter int RECIP3_SHIFT = chest_pkg::RECIP3_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              nrs_shift,
  output logic [1:0]              rd_addr,
  input  logic signed [WIDTH-1:0] est_r,
  input  logic signed [WIDTH-1:0] est_i,
  output logic signed [WIDTH-1:0] h_r,
  output logic signed [WIDTH-1:0] h_i,
  output logic [3:0]              h_sc,
  output logic                    h_valid,
  output logic                    busy,
  output logic                    done
);

  state_t                  r_state;
  logic [1:0]              r_cnt;
  logic [3:0]              r_sc;
  logic                    r_hi;    // k0 >= 3: symbol-6 pilot comes first
  logic [1:0]              r_p;     // first combined pilot position
  logic signed [WIDTH-1:0] r_pr [NUM_PILOTS];
  logic signed [WIDTH-1:0] r_pi [NUM_PILOTS];

  logic [2:0]              w_k0;
  logic                    w_hi;
  logic [1:0]              w_p;
  logic [3:0]              w_d;
  logic [1:0]              w_m;
  logic [1:0]              w_r;
  logic [1:0]              w_idx_a;
  logic [1:0]              w_idx_b;
  logic                    w_pass;
  logic                    w_near_b;
  logic signed [WIDTH-1:0] w_q_r;
  logic signed [WIDTH-1:0] w_q_i;

  // Shift decode from the live input; only used on the accepting edge.
  always_comb begin
    w_k0 = (nrs_shift >= 3'd6) ? (nrs_shift - 3'd6) : nrs_shift;
    w_hi = (w_k0 >= 3'd3);
    w_p  = w_hi ? 2'(w_k0 - 3'd3) : w_k0[1:0];
  end

  // Locate subcarrier r_sc on the pilot grid p + 3m. Outside the pilot span
  // the nearest edge pilot is held; on a pilot it is passed through exactly.
  always_comb begin
    w_d      = r_sc - {2'b00, r_p};
    w_m      = 2'(w_d / 4'(PILOT_SPACING));
    w_r      = 2'(w_d % 4'(PILOT_SPACING));
    w_idx_a  = w_m;
    w_idx_b  = w_m + 2'd1;
    w_pass   = (w_r == 2'd0);
    w_near_b = (w_r == 2'd2);
    if (r_sc < {2'b00, r_p}) begin
      w_idx_a = 2'd0;
      w_pass  = 1'b1;
    end else if (w_d > 4'((NUM_PILOTS - 1) * PILOT_SPACING)) begin
      w_idx_a = 2'(NUM_PILOTS - 1);
      w_pass  = 1'b1;
    end
  end

  chest_interp_div3 #(
    .WIDTH        (WIDTH),
    .RECIP3       (RECIP3),
    .RECIP3_SHIFT (RECIP3_SHIFT)
  ) u_div3_r (
    .i_tap_a  (r_pr[w_idx_a]),
    .i_tap_b  (r_pr[w_idx_b]),
    .i_near_b (w_near_b),
    .o_quot   (w_q_r)
  );

  chest_interp_div3 #(
    .WIDTH        (WIDTH),
    .RECIP3       (RECIP3),
    .RECIP3_SHIFT (RECIP3_SHIFT)
  ) u_div3_i (
    .i_tap_a  (r_pi[w_idx_a]),
    .i_tap_b  (r_pi[w_idx_b]),
    .i_near_b (w_near_b),
    .o_quot   (w_q_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_sc    <= 4'd0;
      r_hi    <= 1'b0;
      r_p     <= 2'd0;
      rd_addr <= 2'd0;
      h_r     <= '0;
      h_i     <= '0;
      h_sc    <= 4'd0;
      h_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NUM_PILOTS; i++) begin
        r_pr[i] <= '0;
        r_pi[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Idle also covers the cycle after the last sample, so a start
          // there chains frames with a single-cycle gap.
          h_valid <= 1'b0;
          done    <= 1'b0;
          busy    <= start;
          if (start) begin
            r_state <= ST_LOAD;
            r_hi    <= w_hi;
            r_p     <= w_p;
            r_cnt   <= 2'd0;
            rd_addr <= sorted_addr(w_hi, 2'd0);
          end
        end
        ST_LOAD: begin
          r_pr[r_cnt] <= est_r;
          r_pi[r_cnt] <= est_i;
          if (r_cnt == 2'(NUM_PILOTS - 1)) begin
            r_state <= ST_OUT;
            r_sc    <= 4'd0;
          end else begin
            r_cnt   <= r_cnt + 2'd1;
            rd_addr <= sorted_addr(r_hi, r_cnt + 2'd1);
          end
        end
        ST_OUT: begin
          h_r     <= w_pass ? r_pr[w_idx_a] : w_q_r;
          h_i     <= w_pass ? r_pi[w_idx_a] : w_q_i;
          h_sc    <= r_sc;
          h_valid <= 1'b1;
          if (r_sc == 4'(NUM_SC - 1)) begin
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_sc <= r_sc + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chest_freq_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_chest_freq_interp                                         |
// | Description : Self-checking bench for chest_freq_interp. Pilot memory is   |
// |               modelled combinationally; expected samples come from a       |
// |               position-based linear interpolation model.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_chest_freq_interp;

  localparam int WIDTH = 17;
  localparam int c_max = 65535;
  localparam int c_min = -65536;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [2:0]              nrs_shift;
  logic [1:0]              rd_addr;
  logic signed [WIDTH-1:0] est_r;
  logic signed [WIDTH-1:0] est_i;
  logic signed [WIDTH-1:0] h_r;
  logic signed [WIDTH-1:0] h_i;
  logic [3:0]              h_sc;
  logic                    h_valid;
  logic                    busy;
  logic                    done;

  logic signed [WIDTH-1:0] mem_r [4];
  logic signed [WIDTH-1:0] mem_i [4];

  int n_checks = 0;
  int n_errors = 0;
  int exp_r [12];
  int exp_i [12];
  int exp_addr [4];

  assign est_r = mem_r[rd_addr];
  assign est_i = mem_i[rd_addr];

  always #5 clk = ~clk;

  chest_freq_interp #(
    .WIDTH        (WIDTH),
    .NUM_SC       (12),
    .RECIP3       (683),
    .RECIP3_SHIFT (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrs_shift (nrs_shift),
    .rd_addr   (rd_addr),
    .est_r     (est_r),
    .est_i     (est_i),
    .h_r       (h_r),
    .h_i       (h_i),
    .h_sc      (h_sc),
    .h_valid   (h_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // floor(S * 683 / 2048), clamped to the output range
  function automatic int div3_ref(input int s);
    longint prod;
    longint q;
    prod = longint'(s) * 683;
    q    = prod / 2048;
    if ((prod % 2048) != 0 && prod < 0) q = q - 1;
    if (q > c_max) q = c_max;
    if (q < c_min) q = c_min;
    return int'(q);
  endfunction

  // Place each pilot at its subcarrier, sort by position, then interpolate
  // linearly between neighbours (edges held flat).
  task automatic build_model(input int sh);
    int  k0, k1, best, j, d;
    int  pos [4];
    int  sp [4];
    int  pr [4];
    int  pi [4];
    bit  used [4];
    k0 = sh % 6;
    k1 = (k0 + 3) % 6;
    pos[0] = k0; pos[1] = k0 + 6; pos[2] = k1; pos[3] = k1 + 6;
    for (int a = 0; a < 4; a++) used[a] = 1'b0;
    for (int slot = 0; slot < 4; slot++) begin
      best = -1;
      for (int a = 0; a < 4; a++)
        if (!used[a] && (best < 0 || pos[a] < pos[best])) best = a;
      used[best]     = 1'b1;
      exp_addr[slot] = best;
      sp[slot]       = pos[best];
      pr[slot]       = int'(mem_r[best]);
      pi[slot]       = int'(mem_i[best]);
    end
    for (int s = 0; s < 12; s++) begin
      if (s <= sp[0]) begin
        exp_r[s] = pr[0]; exp_i[s] = pi[0];
      end else if (s >= sp[3]) begin
        exp_r[s] = pr[3]; exp_i[s] = pi[3];
      end else begin
        j = 0;
        while (sp[j+1] <= s) j++;
        d = s - sp[j];
        if (d == 0) begin
          exp_r[s] = pr[j]; exp_i[s] = pi[j];
        end else begin
          exp_r[s] = div3_ref((3 - d) * pr[j] + d * pr[j+1]);
          exp_i[s] = div3_ref((3 - d) * pi[j] + d * pi[j+1]);
        end
      end
    end
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < 4; a++) begin
      mem_r[a] = WIDTH'($urandom);
      mem_i[a] = WIDTH'($urandom);
    end
  endtask

  // Called just after a negedge. Launches a frame, checks LOAD addressing and
  // all 12 samples at fixed latency. extra_start pulses start into E3;
  // chain_next leaves start high so the next frame is accepted at E17.
  task automatic run_frame(input int sh, input bit extra_start, input bit chain_next);
    build_model(sh);
    start     = 1'b1;
    nrs_shift = 3'(sh);
    @(posedge clk);                       // E0
    @(negedge clk);
    start     = 1'b0;
    nrs_shift = 3'($urandom);             // must be ignored mid-frame
    chk("busy after E0", int'(busy), 1);
    chk("h_valid gap", int'(h_valid), 0);
    chk("done gap", int'(done), 0);
    chk("rd_addr slot0", int'(rd_addr), exp_addr[0]);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rd_addr slot%0d", c), int'(rd_addr), exp_addr[c]);
      if (extra_start && c == 2) start = 1'b1;
    end
    @(negedge clk);                       // after E4
    chk("h_valid before E5", int'(h_valid), 0);
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);                     // after E5+s
      chk($sformatf("h_valid sc%0d", s), int'(h_valid), 1);
      chk($sformatf("h_sc sc%0d", s), int'(h_sc), s);
      chk($sformatf("h_r sc%0d", s), int'(h_r), exp_r[s]);
      chk($sformatf("h_i sc%0d", s), int'(h_i), exp_i[s]);
      chk($sformatf("done sc%0d", s), int'(done), (s == 11) ? 1 : 0);
      chk($sformatf("busy sc%0d", s), int'(busy), 1);
    end
    if (chain_next) begin
      start = 1'b1;
    end else begin
      @(negedge clk);                     // after E17
      chk("busy after E17", int'(busy), 0);
      chk("h_valid after E17", int'(h_valid), 0);
      chk("done after E17", int'(done), 0);
      chk("h_sc hold", int'(h_sc), 11);
      chk("h_r hold", int'(h_r), exp_r[11]);
      chk("h_i hold", int'(h_i), exp_i[11]);
    end
  endtask

  task automatic reset_mid_frame(input int sh);
    start     = 1'b1;
    nrs_shift = 3'(sh);
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);            // through E8
    #1;
    chk("h_valid mid-OUT", int'(h_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst h_r", int'(h_r), 0);
    chk("rst h_i", int'(h_i), 0);
    chk("rst h_sc", int'(h_sc), 0);
    chk("rst h_valid", int'(h_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst rd_addr", int'(rd_addr), 0);
    repeat (3) begin
      @(negedge clk);
      chk("done during rst", int'(done), 0);
    end
    rst = 1'b0;
    repeat (13) begin
      @(negedge clk);
      chk("no done after abort", int'(done), 0);
      chk("idle after abort", int'(busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    nrs_shift = 3'd0;
    for (int a = 0; a < 4; a++) begin
      mem_r[a] = '0;
      mem_i[a] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset h_r", int'(h_r), 0);
    chk("reset h_i", int'(h_i), 0);
    chk("reset h_sc", int'(h_sc), 0);
    chk("reset h_valid", int'(h_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Positive ramp: P0..P3 = 300,600,900,1200 (addr 0,2,1,3)
    mem_r[0] = 17'sd300; mem_r[2] = 17'sd600; mem_r[1] = 17'sd900; mem_r[3] = 17'sd1200;
    for (int a = 0; a < 4; a++) mem_i[a] = '0;
    run_frame(0, 1'b0, 1'b0);

    // Negative ramp exercises floor rounding
    mem_r[0] = -17'sd300; mem_r[2] = -17'sd600; mem_r[1] = -17'sd900; mem_r[3] = -17'sd1200;
    for (int a = 0; a < 4; a++) mem_i[a] = WIDTH'($urandom);
    run_frame(0, 1'b0, 1'b0);

    // Reversed ordering, k0 = 4
    mem_r[0] = 17'sd10; mem_r[1] = 17'sd20; mem_r[2] = 17'sd30; mem_r[3] = 17'sd40;
    run_frame(4, 1'b0, 1'b0);

    // Ignored start at E3, then a chained frame accepted at E17
    randomize_mem();
    run_frame(int'($urandom_range(0, 7)), 1'b1, 1'b1);
    randomize_mem();
    run_frame(int'($urandom_range(0, 7)), 1'b0, 1'b0);

    // Abort mid-OUT, then a clean frame
    randomize_mem();
    reset_mid_frame(int'($urandom_range(0, 7)));
    randomize_mem();
    run_frame(2, 1'b0, 1'b0);

    // Shift 7 behaves as 1; full-scale pilots must not wrap
    randomize_mem();
    mem_r[0] = 17'sd65535;  mem_r[2] = 17'sd65535;
    mem_i[0] = -17'sd65536; mem_i[2] = -17'sd65536;
    run_frame(7, 1'b0, 1'b0);
    mem_r[0] = -17'sd65536; mem_r[2] = -17'sd65536;
    mem_i[0] = 17'sd65535;  mem_i[2] = 17'sd65535;
    run_frame(1, 1'b0, 1'b0);

    // Random frames, some chained back to back
    for (int n = 0; n < 20; n++) begin
      randomize_mem();
      run_frame(int'($urandom_range(0, 7)), 1'b0, (n < 19) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
